// File: rtl/harness_pkg.sv
// Shared types and default parameters for the CPU I/O harness.
package harness_pkg;

   localparam int unsigned DATA_W_DEF    = 64;
   localparam int unsigned OUT_DEPTH_DEF = 16;
   localparam int unsigned IN_DEPTH_DEF  = 8;
   localparam int unsigned CYC_W_DEF     = 32;
   localparam int unsigned TIMEOUT_DEF   = 100000;

   typedef logic [2:0] harness_state_t;

   localparam harness_state_t ST_IDLE    = 3'd0;
   localparam harness_state_t ST_RUN     = 3'd1;
   localparam harness_state_t ST_DRAIN   = 3'd2;
   localparam harness_state_t ST_DONE    = 3'd3;
   localparam harness_state_t ST_TIMEOUT = 3'd4;

   // Trace entry layout at default widths; the harness packs {data, cycle} in this order.
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [CYC_W_DEF-1:0]  cycle;
   } trace_entry_t;

endpackage

// File: rtl/cpu_io_harness_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push on full is accepted only alongside a pop.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             full, empty, push_ok, pop_ok;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count = wr_ptr_q - rd_ptr_q;
   assign rdata = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/cpu_io_harness.sv
// Run-control harness around the CPU I/O ports: output trace capture, input feeding, watchdog.
module cpu_io_harness
   import harness_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF,
   parameter int unsigned IN_DEPTH  = IN_DEPTH_DEF,
   parameter int unsigned CYC_W     = CYC_W_DEF,
   parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              cpu_halt,
   input  logic              cpu_out_signal,
   input  logic [DATA_W-1:0] cpu_out_data,
   input  logic              cpu_in_req,
   output logic              cpu_in_signal,
   output logic [DATA_W-1:0] cpu_in_data,
   input  logic              host_in_valid,
   input  logic [DATA_W-1:0] host_in_data,
   output logic              host_in_ready,
   output logic              trace_valid,
   output logic [DATA_W-1:0] trace_data,
   output logic [CYC_W-1:0]  trace_cycle,
   input  logic              trace_ready,
   output logic              running,
   output logic              done,
   output logic              timed_out,
   output logic              overflow,
   output logic              underflow,
   output logic [CYC_W-1:0]  cycle_count
);

   localparam int unsigned TR_W  = DATA_W + CYC_W;
   localparam int unsigned TR_CW = $clog2(OUT_DEPTH) + 1;
   localparam int unsigned IN_CW = $clog2(IN_DEPTH) + 1;
   localparam logic [CYC_W-1:0] WD_LAST = CYC_W'(TIMEOUT - 1);

   harness_state_t    state_q, state_d;
   logic [CYC_W-1:0]  cycle_count_q, cycle_count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              cpu_in_signal_q, cpu_in_signal_d;
   logic [DATA_W-1:0] cpu_in_data_q, cpu_in_data_d;

   logic [TR_CW-1:0]  tr_count;
   logic [IN_CW-1:0]  in_count;
   logic [TR_W-1:0]   tr_rdata;
   logic [DATA_W-1:0] in_rdata;
   logic              tr_empty, tr_full, in_empty, in_full;
   logic              in_run, tr_push, tr_pop, in_pop, tr_flush;

   assign in_run   = (state_q == ST_RUN);
   assign tr_empty = (tr_count == '0);
   assign tr_full  = (tr_count == TR_CW'(OUT_DEPTH));
   assign in_empty = (in_count == '0);
   assign in_full  = (in_count == IN_CW'(IN_DEPTH));
   assign tr_push  = in_run && cpu_out_signal;
   assign tr_pop   = !tr_empty && trace_ready;
   assign in_pop   = in_run && cpu_in_req && !in_empty;

   sync_fifo #(.WIDTH(TR_W), .DEPTH(OUT_DEPTH)) u_trace_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (tr_flush),
      .push  (tr_push),
      .pop   (tr_pop),
      .wdata ({cpu_out_data, cycle_count_q}),
      .rdata (tr_rdata),
      .count (tr_count)
   );

   // Host pushes straight in; on a full queue only a same-cycle CPU pop makes room.
   sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (1'b0),
      .push  (host_in_valid),
      .pop   (in_pop),
      .wdata (host_in_data),
      .rdata (in_rdata),
      .count (in_count)
   );

   always_comb begin
      state_d         = state_q;
      cycle_count_d   = cycle_count_q;
      overflow_d      = overflow_q;
      underflow_d     = underflow_q;
      cpu_in_signal_d = in_pop;
      cpu_in_data_d   = in_pop ? in_rdata : cpu_in_data_q;
      tr_flush        = 1'b0;

      if (in_run) begin
         if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CYC_W'(1);
         if (tr_push && tr_full && !tr_pop) overflow_d = 1'b1;
         if (cpu_in_req && in_empty) underflow_d = 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_DONE, ST_TIMEOUT: begin
            if (start) begin
               state_d       = ST_RUN;
               cycle_count_d = '0;
               overflow_d    = 1'b0;
               underflow_d   = 1'b0;
               tr_flush      = 1'b1;
            end
         end
         // Halt has priority over the watchdog in the same cycle.
         ST_RUN: begin
            if (cpu_halt) begin
               state_d = ST_DRAIN;
            end else if ((TIMEOUT != 0) && (cycle_count_q == WD_LAST)) begin
               state_d = ST_TIMEOUT;
            end
         end
         ST_DRAIN: begin
            if (tr_empty || (tr_pop && (tr_count == TR_CW'(1)))) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         cycle_count_q   <= '0;
         overflow_q      <= 1'b0;
         underflow_q     <= 1'b0;
         cpu_in_signal_q <= 1'b0;
         cpu_in_data_q   <= '0;
      end else begin
         state_q         <= state_d;
         cycle_count_q   <= cycle_count_d;
         overflow_q      <= overflow_d;
         underflow_q     <= underflow_d;
         cpu_in_signal_q <= cpu_in_signal_d;
         cpu_in_data_q   <= cpu_in_data_d;
      end
   end

   assign cpu_in_signal = cpu_in_signal_q;
   assign cpu_in_data   = cpu_in_data_q;
   assign host_in_ready = !in_full;
   assign trace_valid   = !tr_empty;
   assign trace_data    = tr_empty ? '0 : tr_rdata[TR_W-1 -: DATA_W];
   assign trace_cycle   = tr_empty ? '0 : tr_rdata[CYC_W-1:0];
   assign running       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done          = (state_q == ST_DONE);
   assign timed_out     = (state_q == ST_TIMEOUT);
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;
   assign cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_cpu_io_harness.sv
// Directed bench for cpu_io_harness with a small trace FIFO and a short watchdog.
module tb_cpu_io_harness;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CYC_W  = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              cpu_halt = 1'b0;
   logic              cpu_out_signal = 1'b0;
   logic [DATA_W-1:0] cpu_out_data = '0;
   logic              cpu_in_req = 1'b0;
   logic              cpu_in_signal;
   logic [DATA_W-1:0] cpu_in_data;
   logic              host_in_valid = 1'b0;
   logic [DATA_W-1:0] host_in_data = '0;
   logic              host_in_ready;
   logic              trace_valid;
   logic [DATA_W-1:0] trace_data;
   logic [CYC_W-1:0]  trace_cycle;
   logic              trace_ready = 1'b0;
   logic              running, done, timed_out, overflow, underflow;
   logic [CYC_W-1:0]  cycle_count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   cpu_io_harness #(
      .DATA_W(DATA_W), .OUT_DEPTH(4), .IN_DEPTH(8), .CYC_W(CYC_W), .TIMEOUT(20)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .cpu_halt(cpu_halt),
      .cpu_out_signal(cpu_out_signal), .cpu_out_data(cpu_out_data),
      .cpu_in_req(cpu_in_req), .cpu_in_signal(cpu_in_signal), .cpu_in_data(cpu_in_data),
      .host_in_valid(host_in_valid), .host_in_data(host_in_data), .host_in_ready(host_in_ready),
      .trace_valid(trace_valid), .trace_data(trace_data), .trace_cycle(trace_cycle),
      .trace_ready(trace_ready), .running(running), .done(done), .timed_out(timed_out),
      .overflow(overflow), .underflow(underflow), .cycle_count(cycle_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic [63:0] exp_in_data;
      logic        exp_sig;
      int          c;

      // Reset state
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_running", running, 0);
      chk("rst_done", done, 0);
      chk("rst_timed_out", timed_out, 0);
      chk("rst_trace_valid", trace_valid, 0);
      chk("rst_host_in_ready", host_in_ready, 1);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_cpu_in_signal", cpu_in_signal, 0);
      chk("rst_cpu_in_data", cpu_in_data, 0);
      chk("rst_trace_data", trace_data, 0);

      // Reset in the middle of a run with three trace entries queued
      do_start();
      cpu_out_signal = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cpu_out_data = 64'(32'h50 + i);
         tick();
      end
      cpu_out_signal = 1'b0;
      chk("mid_running", running, 1);
      chk("mid_trace_valid", trace_valid, 1);
      reset = 1'b1;
      #2;
      chk("mid_rst_running", running, 0);
      chk("mid_rst_trace_valid", trace_valid, 0);
      chk("mid_rst_host_in_ready", host_in_ready, 1);
      @(posedge clk);
      #1 reset = 1'b0;
      tick();
      chk("mid_rst_cycle_count", cycle_count, 0);
      chk("mid_rst_cpu_in_signal", cpu_in_signal, 0);
      chk("mid_rst_trace_valid2", trace_valid, 0);

      // Basic run: strobes at RUN cycles 2 and 5, halt at 7, host always pops
      trace_ready = 1'b1;
      do_start();
      for (int k = 0; k < 8; k++) begin
         cpu_out_signal = (k == 2) || (k == 5);
         cpu_out_data   = (k == 2) ? 64'h0A : 64'h14;
         cpu_halt       = (k == 7);
         tick();
         if (k == 2) begin
            chk("basic_valid_a", trace_valid, 1);
            chk("basic_data_a", trace_data, 64'h0A);
            chk("basic_cycle_a", trace_cycle, 2);
         end
         if (k == 3) chk("basic_popped_a", trace_valid, 0);
         if (k == 5) begin
            chk("basic_valid_b", trace_valid, 1);
            chk("basic_data_b", trace_data, 64'h14);
            chk("basic_cycle_b", trace_cycle, 5);
         end
         if (k == 7) begin
            chk("basic_drain_running", running, 1);
            chk("basic_drain_done", done, 0);
         end
      end
      cpu_out_signal = 1'b0;
      cpu_halt = 1'b0;
      tick();
      chk("basic_done", done, 1);
      chk("basic_running", running, 0);
      chk("basic_cycle_count", cycle_count, 8);

      // Overflow: six strobes into a four-entry FIFO with no pops
      trace_ready = 1'b0;
      do_start();
      cpu_out_signal = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cpu_out_data = 64'(32'h100 + i);
         tick();
      end
      cpu_out_signal = 1'b0;
      chk("ovf_set", overflow, 1);
      chk("ovf_head_data", trace_data, 64'h100);
      chk("ovf_head_cycle", trace_cycle, 0);
      trace_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk("ovf_pop_valid", trace_valid, 1);
         chk("ovf_pop_data", trace_data, 64'(32'h100 + j));
         chk("ovf_pop_cycle", trace_cycle, 64'(j));
         tick();
      end
      chk("ovf_emptied", trace_valid, 0);
      cpu_halt = 1'b1;
      tick();
      cpu_halt = 1'b0;
      tick();
      chk("ovf_done", done, 1);

      // Full FIFO with a pop in the fifth push cycle: nothing is dropped
      trace_ready = 1'b0;
      do_start();
      chk("ovf2_cleared", overflow, 0);
      cpu_out_signal = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cpu_out_data = 64'(32'h200 + i);
         trace_ready  = (i == 4);
         tick();
      end
      cpu_out_signal = 1'b0;
      trace_ready = 1'b0;
      chk("ovf2_no_drop", overflow, 0);
      chk("ovf2_head_data", trace_data, 64'h201);
      chk("ovf2_head_cycle", trace_cycle, 1);
      trace_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk("ovf2_pop_data", trace_data, 64'(32'h201 + j));
         chk("ovf2_pop_cycle", trace_cycle, 64'(1 + j));
         tick();
      end
      chk("ovf2_emptied", trace_valid, 0);
      cpu_halt = 1'b1;
      tick();
      cpu_halt = 1'b0;
      tick();
      chk("ovf2_done", done, 1);

      // Watchdog fires after exactly 20 RUN cycles
      do_start();
      repeat (19) tick();
      chk("wd_cc19", cycle_count, 19);
      chk("wd_not_yet", timed_out, 0);
      chk("wd_still_running", running, 1);
      tick();
      chk("wd_timed_out", timed_out, 1);
      chk("wd_cc20", cycle_count, 20);
      chk("wd_not_running", running, 0);

      // Halt in the last watchdog cycle wins over the timeout
      do_start();
      repeat (19) tick();
      cpu_halt = 1'b1;
      tick();
      cpu_halt = 1'b0;
      chk("wdh_running", running, 1);
      chk("wdh_not_timed_out", timed_out, 0);
      tick();
      chk("wdh_done", done, 1);

      // Input channel: preload two words, requests at RUN cycles 3, 6 and 9
      host_in_valid = 1'b1;
      host_in_data  = 64'h11;
      tick();
      host_in_data  = 64'h22;
      tick();
      host_in_valid = 1'b0;
      do_start();
      exp_in_data = 64'h0;
      for (int k = 0; k < 11; k++) begin
         cpu_in_req = (k == 3) || (k == 6) || (k == 9);
         tick();
         c = k + 1;
         exp_sig = (c == 4) || (c == 7);
         if (c == 4) exp_in_data = 64'h11;
         if (c == 7) exp_in_data = 64'h22;
         chk("in_signal", cpu_in_signal, exp_sig);
         chk("in_data", cpu_in_data, exp_in_data);
         chk("in_underflow", underflow, (c >= 10));
      end
      cpu_in_req = 1'b0;

      // Halt and strobe together on an empty FIFO; DONE waits for the pop
      trace_ready = 1'b0;
      host_in_valid = 1'b1;
      host_in_data  = 64'h33;
      tick();
      host_in_valid = 1'b0;
      cpu_out_signal = 1'b1;
      cpu_out_data   = 64'h55;
      cpu_halt       = 1'b1;
      tick();
      cpu_out_signal = 1'b0;
      cpu_halt       = 1'b0;
      chk("hs_valid", trace_valid, 1);
      chk("hs_data", trace_data, 64'h55);
      chk("hs_cycle", trace_cycle, 12);
      tick();
      tick();
      chk("hs_held_running", running, 1);
      chk("hs_held_not_done", done, 0);
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
      chk("hs_done", done, 1);
      chk("hs_emptied", trace_valid, 0);
      chk("hs_underflow_sticky", underflow, 1);

      // Restart clears flags and keeps the preloaded input word
      do_start();
      chk("rs_underflow_clear", underflow, 0);
      chk("rs_overflow_clear", overflow, 0);
      chk("rs_cycle_count", cycle_count, 0);
      cpu_in_req = 1'b1;
      tick();
      cpu_in_req = 1'b0;
      chk("rs_in_signal", cpu_in_signal, 1);
      chk("rs_in_data", cpu_in_data, 64'h33);
      tick();
      chk("rs_in_signal_off", cpu_in_signal, 0);
      cpu_halt = 1'b1;
      tick();
      cpu_halt = 1'b0;
      tick();
      chk("rs_done", done, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
